// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on request and result.
//
// Operations (sel_i): 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA,
// 8 SLT, 9 SLTU; 10-15 execute as ADD. Arithmetic wraps modulo 2^WIDTH.
// Shifts use b_i[SHW-1:0] as the amount. With SERIAL_SHIFT = 0 shifts go
// through a barrel shifter in one cycle; with SERIAL_SHIFT = 1 a non-zero
// shift moves one bit position per cycle in the SHIFT state.
//
// Ports:
//   clk_i     clock, all state on the rising edge
//   rst_i     synchronous active-high reset
//   valid_i   request valid
//   ready_o   request accepted this cycle (combinational from ready_i)
//   a_i, b_i  operands (WIDTH bits)
//   sel_i     operation select (4 bits)
//   valid_o   result valid
//   ready_i   consumer accepts result
//   result_o  registered result (WIDTH bits)
module alu_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter bit          SERIAL_SHIFT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  typedef enum logic [1:0] {
    ShSll,
    ShSrl,
    ShSra
  } shop_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  shop_e            shop_q, shop_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  shop_e            req_shop;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] work_step;
  logic             accept;
  logic             go_serial;
  logic             last_step;

  assign shamt     = b_i[SHW-1:0];
  assign ready_o   = !rst_i && (state_q == StIdle) && (!valid_q || ready_i);
  assign accept    = valid_i && ready_o;
  assign go_serial = SERIAL_SHIFT && is_shift && (shamt != '0);
  assign last_step = (cnt_q == SHW'(1));

  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Single-cycle result. In serial builds the shift cases only matter for a
  // zero amount, so they collapse to a_i and no barrel shifter is built.
  always_comb begin
    is_shift = 1'b0;
    req_shop = ShSll;
    alu_res  = a_i + b_i;
    case (sel_i)
      OpAdd: alu_res = a_i + b_i;
      OpSub: alu_res = a_i + ~b_i + WIDTH'(1);
      OpXor: alu_res = a_i ^ b_i;
      OpOr:  alu_res = a_i | b_i;
      OpAnd: alu_res = a_i & b_i;
      OpSll: begin
        is_shift = 1'b1;
        req_shop = ShSll;
        alu_res  = SERIAL_SHIFT ? a_i : (a_i << shamt);
      end
      OpSrl: begin
        is_shift = 1'b1;
        req_shop = ShSrl;
        alu_res  = SERIAL_SHIFT ? a_i : (a_i >> shamt);
      end
      OpSra: begin
        is_shift = 1'b1;
        req_shop = ShSra;
        alu_res  = SERIAL_SHIFT ? a_i : WIDTH'($signed(a_i) >>> shamt);
      end
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: alu_res = a_i + b_i;
    endcase
  end

  // One bit position of the serial shifter.
  always_comb begin
    case (shop_q)
      ShSll:   work_step = {work_q[WIDTH-2:0], 1'b0};
      ShSrl:   work_step = {1'b0, work_q[WIDTH-1:1]};
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  // State register (control and datapath).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      work_q   <= '0;
      cnt_q    <= '0;
      shop_q   <= ShSll;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && go_serial) state_d = StShift;
      StShift: if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output register updates.
  always_comb begin
    work_d   = work_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    result_d = result_q;
    // A held result drops once consumed; a new result below overrides this.
    valid_d  = valid_q && !ready_i;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (go_serial) begin
            work_d = a_i;
            cnt_d  = shamt;
            shop_d = req_shop;
          end else begin
            result_d = alu_res;
            valid_d  = 1'b1;
          end
        end
      end
      StShift: begin
        work_d = work_step;
        cnt_d  = cnt_q - SHW'(1);
        if (last_step) begin
          result_d = work_step;
          valid_d  = 1'b1;
        end
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances (32-bit barrel, 32-bit serial, 16-bit
// serial). Expected results are queued on accept and checked on handshake.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vi;
  logic [2:0]  ri;
  logic [2:0]  vo;
  logic [2:0]  ro;
  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic [3:0]  sel_s [3];
  logic [31:0] res0;
  logic [31:0] res1;
  logic [15:0] res2;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [31:0] exp2 [$];
  logic [31:0] mon_got;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .SERIAL_SHIFT(1'b0)) u_bar (
    .clk_i(clk), .rst_i(rst), .valid_i(vi[0]), .ready_o(ro[0]), .a_i(a_s[0]), .b_i(b_s[0]),
    .sel_i(sel_s[0]), .valid_o(vo[0]), .ready_i(ri[0]), .result_o(res0)
  );

  alu_pipe #(.WIDTH(32), .SERIAL_SHIFT(1'b1)) u_ser (
    .clk_i(clk), .rst_i(rst), .valid_i(vi[1]), .ready_o(ro[1]), .a_i(a_s[1]), .b_i(b_s[1]),
    .sel_i(sel_s[1]), .valid_o(vo[1]), .ready_i(ri[1]), .result_o(res1)
  );

  alu_pipe #(.WIDTH(16), .SERIAL_SHIFT(1'b1)) u_s16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi[2]), .ready_o(ro[2]), .a_i(a_s[2][15:0]),
    .b_i(b_s[2][15:0]), .sel_i(sel_s[2]), .valid_o(vo[2]), .ready_i(ri[2]), .result_o(res2)
  );

  function automatic void q_push(input int d, input logic [31:0] v);
    case (d)
      0:       exp0.push_back(v);
      1:       exp1.push_back(v);
      default: exp2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return exp0.size();
      1:       return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic logic [31:0] q_pop(input int d);
    case (d)
      0:       return exp0.pop_front();
      1:       return exp1.pop_front();
      default: return exp2.pop_front();
    endcase
  endfunction

  function automatic logic [31:0] res_of(input int d);
    case (d)
      0:       return res0;
      1:       return res1;
      default: return {16'h0, res2};
    endcase
  endfunction

  // Reference model written from the operation table.
  function automatic logic [31:0] model(input int w, input logic [3:0] sel,
                                        input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] mask, a, b, r;
    logic signed [31:0] sa, sb;
    int sh;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    sa = (w == 32) ? a : {{16{a[15]}}, a[15:0]};
    sb = (w == 32) ? b : {{16{b[15]}}, b[15:0]};
    sh = (w == 32) ? int'(b[4:0]) : int'(b[3:0]);
    case (sel)
      4'd1:    r = a - b;
      4'd2:    r = a ^ b;
      4'd3:    r = a | b;
      4'd4:    r = a & b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = sa >>> sh;
      4'd8:    r = {31'b0, sa < sb};
      4'd9:    r = {31'b0, a < b};
      default: r = a + b;
    endcase
    return r & mask;
  endfunction

  // Scoreboard: a result transfers on the coming edge when valid_o && ready_i.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vo[d] && ri[d]) begin
        mon_got = res_of(d);
        checks++;
        if (q_size(d) == 0) begin
          $display("FAIL scoreboard dut%0d: unexpected result %h, required none", d, mon_got);
        end else begin
          mon_exp = q_pop(d);
          if (mon_got !== mon_exp)
            $display("FAIL result dut%0d: got %h, required %h", d, mon_got, mon_exp);
          else
            passes++;
        end
      end
    end
  end

  task automatic issue(input int d, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    int t;
    bit ok;
    vi[d] = 1'b1;
    a_s[d] = a;
    b_s[d] = b;
    sel_s[d] = sel;
    t = 0;
    ok = 1'b0;
    while (t < 200) begin
      @(negedge clk);
      if (ro[d]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      if (push) q_push(d, exp);
    end else begin
      checks++;
      $display("FAIL accept dut%0d: ready_o got 0 for 200 cycles, required 1", d);
    end
    vi[d] = 1'b0;
    a_s[d] = $urandom;
    b_s[d] = $urandom;
    sel_s[d] = 4'($urandom);
  endtask

  // Counts negedges after the accept edge until valid_o is seen.
  task automatic lat(input int d, output int n, output int ro_hi);
    n = 0;
    ro_hi = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (vo[d]) break;
      if (ro[d]) ro_hi++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int d);
    int t = 0;
    while (q_size(d) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q_size(d) == 0) passes++;
    else $display("FAIL drain dut%0d: got %0d outstanding, required 0", d, q_size(d));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ro, vo} !== 6'b0) $display("FAIL reset_hs: got ro=%b vo=%b, required 000/000", ro, vo);
    else passes++;
    checks++;
    if (res0 !== 32'h0) $display("FAIL reset_res0: got %h, required 0", res0);
    else passes++;
    checks++;
    if (res1 !== 32'h0) $display("FAIL reset_res1: got %h, required 0", res1);
    else passes++;
    checks++;
    if (res2 !== 16'h0) $display("FAIL reset_res2: got %h, required 0", res2);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ro !== 3'b111) $display("FAIL ready_after_reset: got %b, required 111", ro);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    ri[0] = 1'b1;
    issue(0, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    issue(0, 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1);
    issue(0, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b1);
    issue(0, 4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b1);
    issue(0, 4'd4, 32'hF0F0_FFFF, 32'h3C3C_0F0F, 32'h3030_0F0F, 1'b1);
    issue(0, 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
    issue(0, 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    issue(0, 4'd8, 32'h5, 32'hFFFF_FFFD, 32'h0, 1'b1);
    issue(0, 4'd9, 32'h5, 32'hFFFF_FFFD, 32'h1, 1'b1);
    issue(0, 4'd12, 32'h3, 32'h4, 32'h7, 1'b1);
    issue(0, 4'd5, 32'h1, 32'd31, 32'h8000_0000, 1'b1);
    issue(0, 4'd6, 32'hFFFF_0000, 32'd20, 32'h0000_0FFF, 1'b1);
    issue(0, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
    issue(0, 4'd6, 32'h0000_0100, 32'h25, 32'h0000_0008, 1'b1);
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    ri[0] = 1'b1;
    vi[0] = 1'b1;
    sel_s[0] = 4'd0;
    a_s[0] = 32'h1;
    b_s[0] = 32'h2;
    @(negedge clk);
    checks++;
    if (ro[0] !== 1'b1) $display("FAIL b2b_ready: got %b, required 1", ro[0]);
    else passes++;
    @(posedge clk);
    #1;
    q_push(0, 32'h3);
    sel_s[0] = 4'd2;
    a_s[0] = 32'hF0;
    b_s[0] = 32'h0F;
    @(negedge clk);
    checks++;
    if ({vo[0], ro[0]} !== 2'b11) $display("FAIL b2b_first: got vo,ro=%b%b, required 11", vo[0], ro[0]);
    else passes++;
    @(posedge clk);
    #1;
    q_push(0, 32'hFF);
    vi[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (vo[0] !== 1'b1) $display("FAIL b2b_second: got vo=%b, required 1", vo[0]);
    else passes++;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (vo[0] !== 1'b0) $display("FAIL b2b_idle: got vo=%b, required 0", vo[0]);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int n, h;
    ri[0] = 1'b0;
    issue(0, 4'd0, 32'd10, 32'd20, 32'd30, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({vo[0], ro[0], res0} !== {1'b1, 1'b0, 32'd30})
        $display("FAIL hold_%0d: got vo=%b ro=%b res=%h, required 1 0 0000001e", i, vo[0], ro[0], res0);
      else
        passes++;
      @(posedge clk);
      #1;
    end
    ri[0] = 1'b1;
    issue(0, 4'd1, 32'd50, 32'd8, 32'd42, 1'b1);
    lat(0, n, h);
    checks++;
    if (n !== 1) $display("FAIL no_bubble: got latency %0d, required 1", n);
    else passes++;
    wait_drain(0);
  endtask

  task automatic test_serial();
    int n_add, n, h;
    ri[1] = 1'b1;
    issue(1, 4'd0, 32'd5, 32'd6, 32'd11, 1'b1);
    lat(1, n_add, h);
    checks++;
    if (n_add !== 1) $display("FAIL ser_add_lat: got %0d, required 1", n_add);
    else passes++;
    issue(1, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
    lat(1, n, h);
    checks++;
    if (n !== 5) $display("FAIL ser_sra_lat: got %0d, required 5", n);
    else passes++;
    checks++;
    if (h !== 0) $display("FAIL ser_sra_busy: got %0d ready cycles, required 0", h);
    else passes++;
    issue(1, 4'd5, 32'h1, 32'd31, 32'h8000_0000, 1'b1);
    lat(1, n, h);
    checks++;
    if (n !== 32) $display("FAIL ser_sll31_lat: got %0d, required 32", n);
    else passes++;
    issue(1, 4'd6, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b1);
    lat(1, n, h);
    checks++;
    if (n !== 1) $display("FAIL ser_shift0_lat: got %0d, required 1", n);
    else passes++;
    wait_drain(1);
  endtask

  task automatic test_reset_mid_shift();
    int n, h, seen;
    ri[1] = 1'b1;
    issue(1, 4'd6, 32'hFFFF_0000, 32'd20, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (vo[1]) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL abandon_valid: got %0d valid cycles, required 0", seen);
    else passes++;
    checks++;
    if (res1 !== 32'h0) $display("FAIL abandon_result: got %h, required 0", res1);
    else passes++;
    @(posedge clk);
    #1;
    issue(1, 4'd0, 32'd2, 32'd3, 32'd5, 1'b1);
    lat(1, n, h);
    checks++;
    if (n !== 1) $display("FAIL post_reset_lat: got %0d, required 1", n);
    else passes++;
    wait_drain(1);
  endtask

  task automatic test_w16();
    int n, h;
    ri[2] = 1'b1;
    issue(2, 4'd7, 32'h8000, 32'd15, 32'hFFFF, 1'b1);
    lat(2, n, h);
    checks++;
    if (n !== 16) $display("FAIL w16_sra15_lat: got %0d, required 16", n);
    else passes++;
    issue(2, 4'd6, 32'h0080, 32'h0013, 32'h0010, 1'b1);
    lat(2, n, h);
    checks++;
    if (n !== 4) $display("FAIL w16_srl_lat: got %0d, required 4", n);
    else passes++;
    wait_drain(2);
  endtask

  task automatic test_random();
    logic [3:0]  sel;
    logic [31:0] a, b;
    int w;
    for (int d = 0; d < 3; d++) begin
      w = (d == 2) ? 16 : 32;
      ri[d] = 1'b1;
      for (int i = 0; i < 30; i++) begin
        sel = 4'($urandom_range(0, 15));
        a = $urandom;
        b = $urandom;
        if (i % 4 == 0) a = a | 32'h8000_8000;
        issue(d, sel, a, b, model(w, sel, a, b), 1'b1);
      end
      wait_drain(d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    vi = 3'b0;
    ri = 3'b0;
    for (int d = 0; d < 3; d++) begin
      a_s[d] = '0;
      b_s[d] = '0;
      sel_s[d] = '0;
    end
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_serial();
    test_reset_mid_shift();
    test_w16();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the core's combinational ALU. Performs add/sub, bitwise logic, shifts and set-less-than (signed/unsigned) on WIDTH-bit operands behind a valid/ready handshake on both sides. Shifts run either through a single-cycle barrel shifter or through a 1-bit-per-cycle serial shifter, selected by parameter, so small-area builds trade shift latency for logic. Sits between the decode/issue stage and writeback.

## Interface
- WIDTH, 32, operand/result width. Power of two, ≥ 8.
- SERIAL_SHIFT, 0, 0 = single-cycle barrel shifter; 1 = iterative shifter, one bit position per cycle.
- clk_i  input  1  clock. Single clock domain; all state updates on the rising edge.
- rst_i  input  1  reset. Synchronous and active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  request can be accepted this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B. Shifts use only the low SHW = log2(WIDTH) bits as the amount.
- sel_i  input  4  operation: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU. Codes 10–15 execute as ADD.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  registered result.

## Operation
- Accept: the request is accepted on a rising edge where valid_i && ready_o.
- ready_o = !rst_i && (state == IDLE) && (!valid_o || ready_i). This path is combinational from ready_i.
- Arithmetic wraps modulo 2^WIDTH. No carry or overflow output.
  - SUB = a_i + ~b_i + 1.
- SLT/SLTU: result = {WIDTH-1 zeros, (a < b)}, compared as two's-complement or unsigned respectively.
- Shifts:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with a_i[WIDTH-1].
- States: IDLE, SHIFT. SHIFT is reachable only when SERIAL_SHIFT = 1.
- IDLE, on accept:
  - Non-shift op, any shift with SERIAL_SHIFT = 0, or shift amount n = 0: compute and register result_o, set valid_o, stay in IDLE.
  - Serial shift with n ≥ 1: load work register = a_i, cnt = n, latch the op, go to SHIFT.
- SHIFT, each edge:
  - Shift the work register one position and decrement cnt.
  - When cnt == 1 at the edge: write the shifted value to result_o, set valid_o, return to IDLE.
  - ready_o is 0 throughout SHIFT.
- Output hold: while valid_o && !ready_i, result_o and valid_o stay stable.
- Output release: valid_o clears on an edge with ready_i = 1, unless a new single-cycle result is written on the same edge. In that case valid_o stays 1 and result_o updates.
- Reset: valid_o = 0, result_o = 0, state = IDLE, cnt = 0.
  - ready_o is 0 while rst_i is high and 1 on the first cycle after reset.
  - Reset during SHIFT abandons the operation; no valid_o pulse follows.
  - Inputs change freely while not accepted; the block samples them only at accept.

## Timing
- Single-cycle ops: accepted at edge k, valid_o high in the cycle after edge k. Throughput is one op per cycle with ready_i held high.
- Serial shift, amount n ≥ 1: accepted at edge k, valid_o high after edge k+n. Latency is n cycles beyond a single-cycle op.
- Serial shift, amount n = 0: same timing as a single-cycle op.
- Worst-case serial latency is WIDTH−1 extra cycles. ready_o returns to 1 in the cycle in which valid_o rises, provided ready_i = 1 or that result is consumed.
- No combinational path from a_i, b_i or sel_i to any output. ready_i → ready_o is the only combinational path.

## Test plan
- WIDTH=32, barrel: ADD 0xFFFFFFFF+0x1 → 0x00000000. SUB 0x0−0x1 → 0xFFFFFFFF. Back-to-back issue with ready_i=1 gives valid_o on 2 consecutive cycles.
- SLT a=0xFFFFFFFF, b=0x1 → 0x1. SLTU with the same operands → 0x0. sel_i=12 with a=3, b=4 → 0x7.
- SERIAL_SHIFT=1:
  - SRA 0x80000000 by 4 → 0xF8000000, valid_o 4 cycles later than for ADD; ready_o low for those 4 cycles.
  - SLL 0x1 by 31 → 0x80000000.
  - Shift by 0 → a_i after 1 cycle.
- Backpressure: hold ready_i=0 for 5 cycles after a result. result_o and valid_o stay constant, ready_o=0. Raising ready_i together with a new valid_i replaces the result with no bubble.
- Reset mid-shift: SRL 0xFFFF0000 by 20, assert rst_i on the 3rd shift cycle. valid_o stays 0 and result_o=0 after reset; a subsequent ADD 2+3 returns 0x5 normally.
- WIDTH=16, SERIAL_SHIFT=1: SRA 0x8000 by 15 → 0xFFFF with 15-cycle extra latency. b_i=0x0013 uses amount 3, so SRL 0x0080 → 0x0010.
